// File: rtl/hex_disp_pkg.sv
// Shared types and constants for the HEX display scheduler: FSM states,
// digit-field geometry and active-low seven-segment glyphs.
package hex_disp_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ROTATE,
    ST_URGENT
  } state_e;

  localparam int DIGIT_W = 7;
  localparam int DIGITS  = 8;
  localparam int SRC_W   = DIGIT_W * DIGITS;

  // Active-low segments: bit0 top .. bit5 upper-left, bit6 middle.
  localparam logic [6:0] DARK = 7'h7F;
  localparam logic [6:0] D0   = 7'h40;
  localparam logic [6:0] D1   = 7'h79;
  localparam logic [6:0] D2   = 7'h24;
  localparam logic [6:0] D3   = 7'h30;
  localparam logic [6:0] D4   = 7'h19;
  localparam logic [6:0] D5   = 7'h12;
  localparam logic [6:0] D6   = 7'h02;
  localparam logic [6:0] D7   = 7'h78;
  localparam logic [6:0] D8   = 7'h00;
  localparam logic [6:0] D9   = 7'h10;
  localparam logic [6:0] DA   = 7'h08;
  localparam logic [6:0] DB   = 7'h03;
  localparam logic [6:0] DC   = 7'h46;
  localparam logic [6:0] DD   = 7'h21;
  localparam logic [6:0] DE   = 7'h06;
  localparam logic [6:0] DF   = 7'h0E;

endpackage

// File: rtl/hex_display_scheduler_if.sv
// Requester-side inputs and HEX-pin outputs of the display scheduler,
// bundled so producers and the scheduler share one connection.
interface hex_display_scheduler_if #(
  parameter int NUM_SRC = 4
) ();
  import hex_disp_pkg::*;

  logic [NUM_SRC-1:0]       src_req_i;
  logic [NUM_SRC-1:0]       src_urgent_i;
  logic [NUM_SRC-1:0]       src_raw_i;
  logic [NUM_SRC*SRC_W-1:0] src_data_i;
  logic                     freeze_i;
  logic [DIGIT_W-1:0]       HEX0_o, HEX1_o, HEX2_o, HEX3_o;
  logic [DIGIT_W-1:0]       HEX4_o, HEX5_o, HEX6_o, HEX7_o;
  logic [NUM_SRC-1:0]       grant_o;
  logic [2:0]               cur_src_o;

  modport master (
    output src_req_i, src_urgent_i, src_raw_i, src_data_i, freeze_i,
    input  HEX0_o, HEX1_o, HEX2_o, HEX3_o, HEX4_o, HEX5_o, HEX6_o, HEX7_o,
    input  grant_o, cur_src_o
  );

  modport slave (
    input  src_req_i, src_urgent_i, src_raw_i, src_data_i, freeze_i,
    output HEX0_o, HEX1_o, HEX2_o, HEX3_o, HEX4_o, HEX5_o, HEX6_o, HEX7_o,
    output grant_o, cur_src_o
  );

endinterface

// File: rtl/hex_seg_encoder.sv
// Combinational 4-bit hex value to active-low seven-segment glyph (0-9, A-F).
module hex_seg_encoder
  import hex_disp_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  always_comb begin
    // NOTE: default assignment first so no path through the case can infer a latch.
    seg = DARK;
    unique case (nibble)
      4'h0: seg = D0;
      4'h1: seg = D1;
      4'h2: seg = D2;
      4'h3: seg = D3;
      4'h4: seg = D4;
      4'h5: seg = D5;
      4'h6: seg = D6;
      4'h7: seg = D7;
      4'h8: seg = D8;
      4'h9: seg = D9;
      4'hA: seg = DA;
      4'hB: seg = DB;
      4'hC: seg = DC;
      4'hD: seg = DD;
      4'hE: seg = DE;
      4'hF: seg = DF;
    endcase
  end

endmodule

// File: rtl/hex_display_scheduler.sv
// Owns the eight HEX digits: round-robin timed pages for requesters, with
// edge-triggered urgent sources preempting the rotation for a fixed hold.
module hex_display_scheduler
  import hex_disp_pkg::*;
#(
  parameter int NUM_SRC     = 4,
  parameter int PAGE_CYCLES = 50_000_000,
  parameter int HOLD_CYCLES = 100_000_000
) (
  input  logic                    clk,
  input  logic                    rst,
  hex_display_scheduler_if.slave  bus
);

  localparam int PAGE_W = (PAGE_CYCLES > 1) ? $clog2(PAGE_CYCLES) : 1;
  localparam int HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [PAGE_W-1:0] PAGE_LAST = PAGE_W'(PAGE_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);

  state_e              state, state_n;
  logic [2:0]          cur_src, cur_n;
  logic [2:0]          resume_src, resume_n;
  logic [PAGE_W-1:0]   page_cnt, page_n;
  logic [HOLD_W-1:0]   hold_cnt, hold_n;
  logic [NUM_SRC-1:0]  urg_q;
  logic [NUM_SRC-1:0]  edges;
  logic                edge_any;
  logic [2:0]          edge_idx;
  logic [NUM_SRC-1:0]  req;
  logic                req_cur;
  logic                req_resume;

  // Nearest requester strictly after 'from', wrapping; 'from' itself is the last resort.
  function automatic logic [2:0] next_after(input logic [2:0] from,
                                            input logic [NUM_SRC-1:0] vec);
    logic [2:0] pick;
    int         idx;
    pick = from;
    for (int i = NUM_SRC; i >= 1; i--) begin
      idx = int'(from) + i;
      if (idx >= NUM_SRC) idx -= NUM_SRC;
      if (vec[idx]) pick = 3'(idx);
    end
    return pick;
  endfunction

  function automatic logic bit_at(input logic [NUM_SRC-1:0] vec, input logic [2:0] idx);
    logic b;
    b = 1'b0;
    for (int s = 0; s < NUM_SRC; s++)
      if (idx == 3'(s)) b = vec[s];
    return b;
  endfunction

  assign req        = bus.src_req_i;
  assign edges      = bus.src_urgent_i & ~urg_q;
  assign edge_any   = |edges;
  assign req_cur    = bit_at(req, cur_src);
  assign req_resume = bit_at(req, resume_src);

  always_comb begin
    edge_idx = '0;
    for (int s = NUM_SRC - 1; s >= 0; s--)
      if (edges[s]) edge_idx = 3'(s);
  end

  always_comb begin
    state_n  = state;
    cur_n    = cur_src;
    resume_n = resume_src;
    page_n   = page_cnt;
    hold_n   = hold_cnt;
    unique case (state)
      ST_IDLE: begin
        page_n = '0;
        hold_n = '0;
        cur_n  = '0;
        if (edge_any) begin
          state_n = ST_URGENT;
          cur_n   = edge_idx;
        end else if (|req) begin
          state_n = ST_ROTATE;
          cur_n   = next_after(3'(NUM_SRC - 1), req);
        end
      end
      ST_ROTATE: begin
        if (edge_any) begin
          state_n  = ST_URGENT;
          resume_n = cur_src;
          cur_n    = edge_idx;
          hold_n   = '0;
          page_n   = '0;
        end else if (!(|req)) begin
          state_n = ST_IDLE;
          cur_n   = '0;
          page_n  = '0;
        end else if (!req_cur || (page_cnt == PAGE_LAST && !bus.freeze_i)) begin
          cur_n  = next_after(cur_src, req);
          page_n = '0;
        end else if (!bus.freeze_i && page_cnt != PAGE_LAST) begin
          page_n = page_cnt + PAGE_W'(1);
        end
      end
      ST_URGENT: begin
        // Only a strictly higher-priority (lower-index) edge may steal the hold.
        if (edge_any && edge_idx < cur_src) begin
          cur_n  = edge_idx;
          hold_n = '0;
        end else if (hold_cnt == HOLD_LAST) begin
          hold_n = '0;
          page_n = '0;
          if (!(|req)) begin
            state_n = ST_IDLE;
            cur_n   = '0;
          end else begin
            state_n = ST_ROTATE;
            cur_n   = req_resume ? resume_src : next_after(resume_src, req);
          end
        end else begin
          hold_n = hold_cnt + HOLD_W'(1);
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      cur_src    <= '0;
      resume_src <= '0;
      page_cnt   <= '0;
      hold_cnt   <= '0;
      urg_q      <= '0;
    end else begin
      // NOTE: non-blocking so every register samples the pre-edge values together.
      state      <= state_n;
      cur_src    <= cur_n;
      resume_src <= resume_n;
      page_cnt   <= page_n;
      hold_cnt   <= hold_n;
      urg_q      <= bus.src_urgent_i;
    end
  end

  always_comb begin
    for (int s = 0; s < NUM_SRC; s++)
      bus.grant_o[s] = (state != ST_IDLE) && (cur_src == 3'(s));
  end
  assign bus.cur_src_o = cur_src;

  logic [SRC_W-1:0]   sel_data;
  logic               sel_raw;
  logic [DIGIT_W-1:0] digit_next [DIGITS];
  logic [DIGIT_W-1:0] hex_q      [DIGITS];

  always_comb begin
    sel_data = '0;
    sel_raw  = 1'b0;
    for (int s = 0; s < NUM_SRC; s++) begin
      if (cur_src == 3'(s)) begin
        sel_data = bus.src_data_i[s*SRC_W +: SRC_W];
        sel_raw  = bus.src_raw_i[s];
      end
    end
  end

  for (genvar d = 0; d < DIGITS; d++) begin : g_digit
    logic [DIGIT_W-1:0] field;
    logic [6:0]         glyph;
    assign field = sel_data[d*DIGIT_W +: DIGIT_W];
    hex_seg_encoder u_enc (
      .nibble (field[3:0]),
      .seg    (glyph)
    );
    assign digit_next[d] = sel_raw  ? field :
                           field[4] ? DARK  : glyph;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int d = 0; d < DIGITS; d++) hex_q[d] <= DARK;
    end else begin
      for (int d = 0; d < DIGITS; d++)
        hex_q[d] <= (state == ST_IDLE) ? DARK : digit_next[d];
    end
  end

  assign bus.HEX0_o = hex_q[0];
  assign bus.HEX1_o = hex_q[1];
  assign bus.HEX2_o = hex_q[2];
  assign bus.HEX3_o = hex_q[3];
  assign bus.HEX4_o = hex_q[4];
  assign bus.HEX5_o = hex_q[5];
  assign bus.HEX6_o = hex_q[6];
  assign bus.HEX7_o = hex_q[7];

endmodule

// File: tb/tb_hex_display_scheduler.sv
// Directed test-plan steps followed by a random phase, every cycle compared
// against a page/hold reference model of the display scheduler.
module tb_hex_display_scheduler;

  localparam int NS    = 4;
  localparam int PAGE  = 8;
  localparam int HOLD  = 20;
  localparam logic [6:0]  DK   = 7'h7F;
  localparam logic [55:0] DK8  = {8{7'h7F}};

  logic clk;
  logic rst;

  hex_display_scheduler_if #(.NUM_SRC(NS)) bus ();

  hex_display_scheduler #(
    .NUM_SRC     (NS),
    .PAGE_CYCLES (PAGE),
    .HOLD_CYCLES (HOLD)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic [6:0] seg_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  // Reference model: mode 0 = dark/idle, 1 = rotating pages, 2 = urgent hold.
  int          m_mode, m_cur, m_resume, m_age, m_held;
  logic [3:0]  m_prev;
  logic [55:0] m_hex;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [55:0] hexcat();
    return {bus.HEX7_o, bus.HEX6_o, bus.HEX5_o, bus.HEX4_o,
            bus.HEX3_o, bus.HEX2_o, bus.HEX1_o, bus.HEX0_o};
  endfunction

  function automatic int next_req(input int from, input logic [3:0] r);
    for (int i = 1; i <= NS; i++)
      if (r[(from + i) % NS]) return (from + i) % NS;
    return from;
  endfunction

  task automatic model_reset();
    m_mode = 0; m_cur = 0; m_resume = 0; m_age = 0; m_held = 0;
    m_prev = '0; m_hex = DK8;
  endtask

  task automatic model_step();
    logic [3:0] e, r;
    logic [6:0] f;
    int lo;
    if (rst) begin
      model_reset();
      return;
    end
    r = bus.src_req_i;
    e = bus.src_urgent_i & ~m_prev;
    m_prev = bus.src_urgent_i;
    for (int d = 0; d < 8; d++) begin
      if (m_mode == 0) m_hex[d*7 +: 7] = DK;
      else begin
        f = bus.src_data_i[m_cur*56 + d*7 +: 7];
        if (bus.src_raw_i[m_cur]) m_hex[d*7 +: 7] = f;
        else if (f[4])            m_hex[d*7 +: 7] = DK;
        else                      m_hex[d*7 +: 7] = seg_tab[f[3:0]];
      end
    end
    lo = -1;
    for (int s = NS - 1; s >= 0; s--) if (e[s]) lo = s;
    case (m_mode)
      0: begin
        if (lo >= 0) begin m_mode = 2; m_cur = lo; m_held = 0; end
        else if (r != 0) begin m_mode = 1; m_cur = next_req(NS - 1, r); m_age = 0; end
      end
      1: begin
        if (lo >= 0) begin m_mode = 2; m_resume = m_cur; m_cur = lo; m_held = 0; end
        else if (r == 0) begin m_mode = 0; m_cur = 0; end
        else begin
          if (!bus.freeze_i) m_age++;
          if (!r[m_cur] || m_age == PAGE) begin m_cur = next_req(m_cur, r); m_age = 0; end
        end
      end
      default: begin
        if (lo >= 0 && lo < m_cur) begin m_cur = lo; m_held = 0; end
        else begin
          m_held++;
          if (m_held == HOLD) begin
            if (r == 0) begin m_mode = 0; m_cur = 0; end
            else begin
              m_mode = 1; m_age = 0;
              m_cur = r[m_resume] ? m_resume : next_req(m_resume, r);
            end
          end
        end
      end
    endcase
  endtask

  // One clock: advance the model on the same inputs, then compare after the edge.
  task automatic tick();
    logic [3:0] eg;
    model_step();
    @(posedge clk);
    #1;
    eg = (m_mode == 0) ? 4'b0000 : 4'(1 << m_cur);
    check("grant", 64'(bus.grant_o), 64'(eg));
    check("cur_src", 64'(bus.cur_src_o), 64'((m_mode == 0) ? 0 : m_cur));
    check("hex", 64'(hexcat()), 64'(m_hex));
    @(negedge clk);
  endtask

  task automatic wait_grant(input logic [3:0] g, input string tag);
    int n;
    n = 0;
    while (bus.grant_o !== g && n < 60) begin tick(); n++; end
    check(tag, 64'(bus.grant_o), 64'(g));
  endtask

  task automatic run_len(input logic [3:0] g, input int start, output int n);
    n = start;
    for (int i = 0; i < 60; i++) begin
      tick();
      if (bus.grant_o !== g) return;
      n++;
    end
  endtask

  int n;

  initial begin
    rst = 1'b1;
    bus.src_req_i = '0; bus.src_urgent_i = '0; bus.src_raw_i = '0;
    bus.src_data_i = '0; bus.freeze_i = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    check("rst_grant", 64'(bus.grant_o), 64'(4'b0000));
    check("rst_hex", 64'(hexcat()), 64'(DK8));
    check("rst_cur", 64'(bus.cur_src_o), 64'(0));
    rst = 1'b0;
    tick(); tick();

    // Two requesters alternate in 8-cycle pages.
    bus.src_data_i[6:0]         = 7'h03;
    bus.src_data_i[2*56 +: 7]   = 7'h0A;
    bus.src_req_i = 4'b0101;
    for (int i = 0; i < 8; i++) begin
      tick();
      check("rr_s0", 64'(bus.grant_o), 64'(4'b0001));
      if (i > 0) check("rr_hex0", 64'(bus.HEX0_o), 64'(7'b0110000));
    end
    for (int i = 0; i < 8; i++) begin
      tick();
      check("rr_s2", 64'(bus.grant_o), 64'(4'b0100));
    end
    tick();
    check("rr_wrap", 64'(bus.grant_o), 64'(4'b0001));

    // Reset pulse while rotating.
    tick(); tick();
    rst = 1'b1;
    model_reset();
    #1;
    check("mid_rst_grant", 64'(bus.grant_o), 64'(4'b0000));
    check("mid_rst_hex", 64'(hexcat()), 64'(DK8));
    tick();
    check("mid_rst_edge_grant", 64'(bus.grant_o), 64'(4'b0000));
    rst = 1'b0;
    tick();
    check("post_rst_grant", 64'(bus.grant_o), 64'(4'b0001));

    // Single requester keeps its grant across page boundaries.
    bus.src_req_i = 4'b0010;
    for (int i = 0; i < 20; i++) begin
      tick();
      check("single_s1", 64'(bus.grant_o), 64'(4'b0010));
    end

    // Freeze for 5 cycles stretches one page to 13 cycles.
    bus.src_req_i = 4'b1010;
    wait_grant(4'b1000, "wait_s3");
    wait_grant(4'b0010, "wait_s1");
    n = 1;
    for (int i = 0; i < 40; i++) begin
      bus.freeze_i = (i < 5);
      tick();
      if (bus.grant_o !== 4'b0010) break;
      n++;
    end
    bus.freeze_i = 1'b0;
    check("freeze_page_len", 64'(n), 64'(13));

    // Urgent raw banner from s3 preempts an s0 page.
    bus.src_req_i = 4'b0101;
    wait_grant(4'b0001, "wait_s0");
    tick(); tick();
    bus.src_raw_i[3] = 1'b1;
    bus.src_data_i[3*56 +: 7] = 7'b0000110;
    bus.src_urgent_i = 4'b1000;
    tick();
    check("urg_grant", 64'(bus.grant_o), 64'(4'b1000));
    tick();
    check("urg_hex0", 64'(bus.HEX0_o), 64'(7'b0000110));
    run_len(4'b1000, 2, n);
    check("urg_hold_len", 64'(n), 64'(HOLD));
    check("urg_resume", 64'(bus.grant_o), 64'(4'b0001));
    run_len(4'b0001, 1, n);
    check("resume_page_len", 64'(n), 64'(PAGE));
    check("no_reentry", 64'(bus.grant_o), 64'(4'b0100));

    // Simultaneous edges, ignored higher edge, restarting lower edge.
    bus.src_urgent_i = 4'b0000;
    bus.src_raw_i    = 4'b0000;
    bus.src_req_i    = 4'b0100;
    wait_grant(4'b0100, "wait_s2");
    tick();
    bus.src_urgent_i = 4'b0110;
    tick();
    check("simul_cur", 64'(bus.cur_src_o), 64'(1));
    tick(); tick();
    bus.src_urgent_i = 4'b0010;
    tick();
    bus.src_urgent_i = 4'b0110;
    tick();
    check("ignore_s2", 64'(bus.cur_src_o), 64'(1));
    tick();
    bus.src_urgent_i = 4'b0111;
    tick();
    check("restart_s0", 64'(bus.grant_o), 64'(4'b0001));
    run_len(4'b0001, 1, n);
    check("restart_hold_len", 64'(n), 64'(HOLD));
    check("restart_resume_s2", 64'(bus.grant_o), 64'(4'b0100));

    // Current source drops its request, then everything drops.
    bus.src_urgent_i = 4'b0000;
    bus.src_req_i    = 4'b0111;
    wait_grant(4'b0001, "wait_s0_drop");
    tick(); tick();
    bus.src_req_i = 4'b0110;
    tick();
    check("drop_next", 64'(bus.grant_o), 64'(4'b0010));
    tick();
    bus.src_req_i = 4'b0000;
    tick();
    check("idle_grant", 64'(bus.grant_o), 64'(4'b0000));
    check("idle_cur", 64'(bus.cur_src_o), 64'(0));
    tick();
    check("idle_dark", 64'(hexcat()), 64'(DK8));

    // Random traffic against the model.
    for (int c = 0; c < 700; c++) begin
      if ($urandom_range(0, 9) == 0) bus.src_req_i = 4'($urandom);
      for (int s = 0; s < NS; s++)
        if ($urandom_range(0, 29) == 0) bus.src_urgent_i[s] = ~bus.src_urgent_i[s];
      if ($urandom_range(0, 7) == 0) bus.src_raw_i = 4'($urandom);
      for (int k = 0; k < 7; k++) bus.src_data_i[k*32 +: 32] = $urandom;
      bus.freeze_i = ($urandom_range(0, 9) == 0);
      tick();
    end

    $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
    $finish;
  end

endmodule

// File: doc/hex_display_scheduler.md
# hex_display_scheduler

Shares the board's eight active-low seven-segment digits (HEX0..HEX7) between up to NUM_SRC display requesters: game status, distance readout, sensor debug fields. Non-urgent requesters take turns in timed pages. An urgent event, such as a PAUSE or DONE banner, preempts the rotation for a fixed hold time. The block sits between the status and debug producers and the HEX pins, and owns every digit.

## Interface
- NUM_SRC, 4: number of requesters, 2..8.
- PAGE_CYCLES, 50_000_000: cycles each rotating page is shown (1 s at 50 MHz).
- HOLD_CYCLES, 100_000_000: cycles an urgent page is held.
- clk  in  1  system clock; the only clock.
- rst  in  1  asynchronous, active-high reset.
- src_req_i  in  NUM_SRC  source s wants display time (level).
- src_urgent_i  in  NUM_SRC  rising edge on bit s requests preemption by source s.
- src_raw_i  in  NUM_SRC  1: source's digit fields are raw segment patterns; 0: nibble codes.
- src_data_i  in  NUM_SRC*56  source s occupies bits [56s+55:56s], digit d occupies [7d+6:7d].
  - Nibble mode: bits [3:0] are the hex value; bit 4 = 1 blanks the digit; bits [6:5] are ignored.
- freeze_i  in  1  stops the page timer, so the current page is held.
- HEX0_o..HEX7_o  out  7 each  registered segment patterns, active-low (bit0 top, bit1 upper-right, bit2 lower-right, bit3 bottom, bit4 lower-left, bit5 upper-left, bit6 middle).
- grant_o  out  NUM_SRC  one-hot source currently displayed; all zero in IDLE.
- cur_src_o  out  3  index of the displayed source; 0 in IDLE.

## Operation
- States: IDLE, ROTATE, URGENT.
- Urgent edge detection:
  - A per-source registered copy of src_urgent_i marks an edge where the input is 1 and the copy is 0.
  - When several edges occur in one cycle, the lowest index wins and the others are discarded.
- IDLE:
  - All HEX outputs are DARK (7'h7F).
  - Any urgent edge -> URGENT, showing the lowest-index edge source.
  - Otherwise any src_req_i -> ROTATE, showing the lowest-index requester.
  - The page timer is zeroed.
- ROTATE:
  - The page timer increments each cycle unless freeze_i is high.
  - At PAGE_CYCLES-1, or as soon as the current source drops src_req_i, the next requester is selected round-robin, starting after the current index and wrapping.
  - With exactly one requester, it is selected again. The timer is cleared on every selection.
  - No requesters -> IDLE.
  - An urgent edge -> URGENT. The preempted index is saved as resume_src.
- URGENT:
  - The hold counter runs from 0 to HOLD_CYCLES-1 and is not affected by freeze_i.
  - The urgent source's data is shown live, regardless of its src_req_i.
  - An urgent edge from a lower index restarts the hold and switches source. Edges from equal or higher indices are ignored.
  - At expiry: -> ROTATE on resume_src if it still requests, else the next requester after it. If nothing requests -> IDLE.
  - A level held high on src_urgent_i never re-enters URGENT; only a new edge does.
- Digit path:
  - A combinational NUM_SRC:1 mux on the registered selection feeds eight encoders.
  - In raw mode the field passes through unchanged. In nibble mode the field goes through hex_seg_encoder, or becomes DARK when blank.
  - The result is registered into HEXn_o.
- Counters are $clog2-sized and saturate at their terminal count; they never wrap past it.

## Timing
- Reset, and rst asserted mid-operation: state IDLE, all HEX = 7'h7F, grant_o = 0, cur_src_o = 0, counters 0, edge registers 0. Recovery takes effect on the first clk edge after rst falls.
- An urgent edge or request first sampled at clk edge k updates state, grant_o and cur_src_o at edge k. HEX shows the new source from edge k+1.
- In steady state, src_data_i reaches HEXn_o with 1-cycle latency.
- A rotating page lasts exactly PAGE_CYCLES cycles of grant, plus any cycles where freeze_i is high.

## Structure
- hex_disp_pkg holds:
  - the state enum;
  - the DARK constant;
  - segment constants D0..DF;
  - the digit-field width (7) and digits-per-source (8) constants.
- Sub-module hex_seg_encoder is a combinational 4-bit to active-low 7-segment encoder covering 0-9 and A-F. It is instantiated eight times.
- Arbitration and counters live in the top module.

## Test plan
Parameters for the bench: NUM_SRC=4, PAGE_CYCLES=8, HOLD_CYCLES=20.
- Reset, no requests -> all HEX = 7'h7F, grant_o = 4'b0000. Pulse rst mid-ROTATE -> same values at the following edge.
- src_req_i = 4'b0101, nibble data s0 digit0 = 4'h3 -> grant 0001 for 8 cycles with HEX0 = 7'b0110000; then grant 0100 for 8 cycles; then back to 0001.
- Single requester s1 -> grant 0010 continuously; timer expiry reselects s1 with no gap. Hold freeze_i high for 5 cycles -> that page lasts 13 cycles.
- During an s0 page, s3 urgent rises with raw data 7'b0000110 on digit0 -> grant 1000 at the sampling edge, HEX0 = 7'b0000110 one cycle later, held 20 cycles. Then resume on s0 with the page timer cleared.
- Simultaneous urgent edges on s2 and s1 -> s1 wins. A later s2 edge during hold is ignored. An s0 edge during hold restarts the 20-cycle hold on s0.
- Current source drops src_req_i mid-page -> next requester is granted at the following edge. All requests drop -> IDLE, HEX go dark one cycle later.
